// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module : alu_arb_pkg
// Brief  : Opcodes, response-slot state type and default widths for the
//          shared-ALU arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

   localparam int DEFAULT_DATA_W = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_NOP = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module : alu
// Brief  : Combinational ALU, DATA_W wide, wrapping arithmetic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0] srca,
   input  logic [DATA_W-1:0] srcb,
   input  logic [2:0]        ctrl,
   output logic [DATA_W-1:0] result
);

   // Shift amount is the whole of srcb, so any amount >= DATA_W yields zero.
   always_comb begin
      result = '0;
      case (ctrl)
         ALU_ADD: result = srca + srcb;
         ALU_SLL: result = srca << srcb;
         ALU_SUB: result = srca - srcb;
         ALU_XOR: result = srca ^ srcb;
         ALU_SRL: result = srca >> srcb;
         ALU_OR:  result = srca | srcb;
         ALU_AND: result = srca & srcb;
         default: result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant with priority register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic valid0,
   input  logic valid1,
   input  logic slot_free,
   output logic grant,
   output logic accept
);

   logic prio_q;
   logic prio_d;

   // Contention resolved by prio; otherwise whichever side is valid wins.
   always_comb begin
      grant  = (valid0 && valid1) ? prio_q : valid1;
      accept = slot_free && (valid0 || valid1);
      prio_d = accept ? ~grant : prio_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module : alu_share_arbiter
// Brief  : Shares one ALU between two requesters with a one-entry registered
//          response slot. ALU_ARB_STATS_EN adds saturating grant counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_srca,
   input  logic [DATA_W-1:0] req0_srcb,
   input  logic [2:0]        req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_srca,
   input  logic [DATA_W-1:0] req1_srcb,
   input  logic [2:0]        req1_ctrl,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_sign
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
`endif
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("alu_share_arbiter: CNT_W must be at least 1");
   end

   state_t            state_q,  state_d;
   logic              id_q,     id_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q,   zero_d;
   logic              sign_q,   sign_d;

   logic              slot_free;
   logic              grant;
   logic              accept;
   logic [DATA_W-1:0] alu_srca;
   logic [DATA_W-1:0] alu_srcb;
   logic [2:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_result;

   assign slot_free  = (state_q == EMPTY) || rsp_ready;
   assign req0_ready = slot_free && !grant;
   assign req1_ready = slot_free && grant;

   assign alu_srca = grant ? req1_srca : req0_srca;
   assign alu_srcb = grant ? req1_srcb : req0_srcb;
   assign alu_ctrl = grant ? req1_ctrl : req0_ctrl;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .slot_free (slot_free),
      .grant     (grant),
      .accept    (accept)
   );

   alu #(.DATA_W(DATA_W)) u_alu (
      .srca   (alu_srca),
      .srcb   (alu_srcb),
      .ctrl   (alu_ctrl),
      .result (alu_result)
   );

   // Flags are registered rather than derived so reset can force zero=0.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      result_d = result_q;
      zero_d   = zero_q;
      sign_d   = sign_q;
      if (accept) begin
         state_d  = FULL;
         id_d     = grant;
         result_d = alu_result;
         zero_d   = (alu_result == '0);
         sign_d   = alu_result[DATA_W-1];
      end else if ((state_q == FULL) && rsp_ready) begin
         state_d  = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         id_q     <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         sign_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         sign_q   <= sign_d;
      end
   end

   assign rsp_valid  = (state_q == FULL);
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_sign   = sign_q;

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (accept && !grant && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
      if (accept &&  grant && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`else
`endif

endmodule

`default_nettype wire
